// File: rtl/int_controller.sv
// int_controller: interrupt source side of the SCPU INT/eret handshake.
// Latches rising edges on peripheral irq lines into PEND, gates them with MASK
// and the global enable, raises INT to the CPU, and exposes PEND/MASK/CAUSE/CTRL
// as a one-cycle-latency MIO register window.
module int_controller #(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  input  logic             int_ack,
  input  logic             eret,
  output logic             INT,
  input  logic             cs,
  input  logic             mem_w,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             MIO_ready
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t           state, next_state;
  logic [N_SRC-1:0] pend, pend_next, mask, irq_d, edges, active, sel_oh;
  logic [4:0]       cause, sel;
  logic             gie, armed, hit, start, wr, rd, req, take;
  logic [31:0]      rd_val;
  logic             unused_bits;

  // Address bits below the word offset and high write-data bits carry no state.
  assign unused_bits = ^{addr[1:0], wdata};

  // Bus decode: a new access starts only when the previous one is not completing.
  always_comb begin
    hit   = (addr[31:4] == BASE_ADDR[31:4]);
    start = cs & hit & ~MIO_ready;
    wr    = start & mem_w;
    rd    = start & ~mem_w;
  end

  // Edge capture and request arbitration; the first clock after reset only
  // primes the history so lines already high at release are not seen as edges.
  always_comb begin
    edges  = armed ? (irq & ~irq_d) : '0;
    active = pend & mask;
    req    = gie & (|active);
    sel_oh = active & (~active + 1'b1);
    sel    = 5'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel = 5'(i);
    end
    take = (state == REQ) & req & int_ack;
  end

  // Pending update order: W1C, then acknowledge clear, then new edges so a set wins.
  always_comb begin
    pend_next = pend;
    if (wr && addr[3:2] == 2'd0) pend_next = pend_next & ~wdata[N_SRC-1:0];
    if (take) pend_next = pend_next & ~sel_oh;
    pend_next = pend_next | edges;
  end

  // Register read mux; unused bits stay zero.
  always_comb begin
    rd_val = '0;
    case (addr[3:2])
      2'd0:    rd_val[N_SRC-1:0] = pend;
      2'd1:    rd_val[N_SRC-1:0] = mask;
      2'd2:    rd_val[4:0]       = cause;
      default: rd_val[0]         = gie;
    endcase
  end

  // Next-state logic for the INT handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = REQ;
      REQ:     if (!req) next_state = IDLE;
               else if (int_ack) next_state = SVC;
      SVC:     if (eret) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; INT registered from next state so it tracks REQ exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      INT   <= 1'b0;
    end else begin
      state <= next_state;
      INT   <= (next_state == REQ);
    end
  end

  // Edge history, pending/mask/cause/enable registers and bus response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_d     <= '0;
      armed     <= 1'b0;
      pend      <= '0;
      mask      <= '0;
      cause     <= '0;
      gie       <= 1'b0;
      MIO_ready <= 1'b0;
      rdata     <= '0;
    end else begin
      irq_d     <= irq;
      armed     <= 1'b1;
      pend      <= pend_next;
      if (wr && addr[3:2] == 2'd1) mask <= wdata[N_SRC-1:0];
      if (wr && addr[3:2] == 2'd3) gie <= wdata[0];
      if (take) cause <= sel;
      MIO_ready <= start;
      rdata     <= rd ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed bench for int_controller with a scoreboard for
// bus responses and direct checks of INT around the handshake.
module tb_int_controller;

  localparam logic [31:0] A_PEND  = 32'hFFFF_FF00;
  localparam logic [31:0] A_MASK  = 32'hFFFF_FF04;
  localparam logic [31:0] A_CAUSE = 32'hFFFF_FF08;
  localparam logic [31:0] A_CTRL  = 32'hFFFF_FF0C;
  localparam logic [31:0] A_MISS  = 32'hFFFF_FE00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  irq = 8'hFF;
  logic        int_ack = 1'b0, eret = 1'b0, cs = 1'b0, mem_w = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        INT, MIO_ready;
  logic [31:0] rdata;

  typedef struct {
    int          due;
    logic        is_read;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int_controller #(.N_SRC(8), .BASE_ADDR(32'hFFFF_FF00)) dut (
    .clk(clk), .reset(reset), .irq(irq), .int_ack(int_ack), .eret(eret),
    .INT(INT), .cs(cs), .mem_w(mem_w), .addr(addr), .wdata(wdata),
    .rdata(rdata), .MIO_ready(MIO_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed access must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && MIO_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_ready: MIO_ready=1 expected 0 with no access outstanding");
      end else begin
        e = sb.pop_front();
        check_output({e.name, "_latency"}, 32'(cyc), 32'(e.due));
        if (e.is_read) check_output({e.name, "_rdata"}, rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input logic exp);
    @(negedge clk);
    check_output(name, {31'b0, INT}, {31'b0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 5) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: MIO_ready not seen, expected within 1 cycle", name);
      sb.delete();
    end
  endtask

  task automatic bus_access(input string name, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp);
    cs    = 1'b1;
    mem_w = w;
    addr  = a;
    wdata = d;
    sb.push_back('{cyc + 1, !w, exp, name});
    tick();
    cs = 1'b0;
    tick();
    wait_drain(name);
  endtask

  task automatic bus_write(input string name, input logic [31:0] a, input logic [31:0] d);
    bus_access(name, 1'b1, a, d, 32'h0);
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus_access(name, 1'b0, a, 32'h0, exp);
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : apply_stimulus
    // Reset with all lines high; nothing may latch or respond.
    tick();
    tick();
    @(negedge clk);
    check_output("rst_int", {31'b0, INT}, 32'h0);
    check_output("rst_ready", {31'b0, MIO_ready}, 32'h0);
    check_output("rst_rdata", rdata, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    bus_read("t1_pend_high", A_PEND, 32'h0);
    irq = 8'h00;
    bus_read("t1_mask", A_MASK, 32'h0);
    bus_read("t1_cause", A_CAUSE, 32'h0);
    bus_read("t1_ctrl", A_CTRL, 32'h0);

    // Decode miss gives no ready; held cs gives exactly one ready.
    cs = 1'b1; mem_w = 1'b0; addr = A_MISS;
    tick();
    cs = 1'b0;
    @(negedge clk);
    check_output("miss_ready", {31'b0, MIO_ready}, 32'h0);
    tick();
    cs = 1'b1; mem_w = 1'b0; addr = A_CTRL;
    sb.push_back('{cyc + 1, 1'b1, 32'h0, "held_cs"});
    tick();
    tick();
    cs = 1'b0;
    tick();
    wait_drain("held_cs");

    // Single source: INT two cycles after edge, ack, eret.
    bus_write("t2_mask_w", A_MASK, 32'h04);
    bus_write("t2_ctrl_w", A_CTRL, 32'h1);
    bus_read("t2_ctrl_r", A_CTRL, 32'h1);
    irq = 8'h04;
    check_int("t2_int_c0", 1'b0);
    irq = 8'h00;
    check_int("t2_int_c1", 1'b0);
    check_int("t2_int_c2", 1'b1);
    pulse_ack();
    check_int("t2_int_svc", 1'b0);
    bus_read("t2_cause", A_CAUSE, 32'h2);
    bus_read("t2_pend", A_PEND, 32'h0);
    pulse_eret();
    check_int("t2_int_eret0", 1'b0);
    check_int("t2_int_eret1", 1'b0);

    // Two simultaneous sources: lower index first, second after eret.
    bus_write("t3_mask_w", A_MASK, 32'hFF);
    irq = 8'h22;
    tick();
    irq = 8'h00;
    tick();
    check_int("t3_int", 1'b1);
    pulse_ack();
    bus_read("t3_cause1", A_CAUSE, 32'h1);
    bus_read("t3_pend1", A_PEND, 32'h20);
    pulse_eret();
    check_int("t3_int_idle", 1'b0);
    check_int("t3_int_reassert", 1'b1);
    pulse_ack();
    bus_read("t3_cause5", A_CAUSE, 32'h5);
    bus_read("t3_pend0", A_PEND, 32'h0);
    pulse_eret();

    // Masking away a pending request drops INT and returns to IDLE.
    irq = 8'h08;
    check_int("t4_int_c0", 1'b0);
    irq = 8'h00;
    check_int("t4_int_c1", 1'b0);
    check_int("t4_int_c2", 1'b1);
    bus_write("t4_mask0", A_MASK, 32'h0);
    check_int("t4_int_drop", 1'b0);
    bus_read("t4_pend", A_PEND, 32'h08);
    pulse_ack();
    bus_read("t4_cause_kept", A_CAUSE, 32'h5);
    bus_read("t4_pend_kept", A_PEND, 32'h08);
    bus_write("t4_w1c", A_PEND, 32'hFF);
    bus_read("t4_pend_clr", A_PEND, 32'h0);

    // W1C colliding with a new edge: the edge wins; plain W1C still clears.
    irq = 8'h01;
    bus_write("t5_w1c_edge", A_PEND, 32'h01);
    bus_read("t5_pend_set", A_PEND, 32'h1);
    irq = 8'h00;
    bus_write("t5_w1c", A_PEND, 32'h01);
    bus_read("t5_pend_clr", A_PEND, 32'h0);

    // Reset while servicing, during a read completion.
    bus_write("t6_mask_w", A_MASK, 32'h10);
    irq = 8'h10;
    check_int("t6_int_c0", 1'b0);
    irq = 8'h00;
    check_int("t6_int_c1", 1'b0);
    check_int("t6_int_c2", 1'b1);
    pulse_ack();
    bus_read("t6_cause", A_CAUSE, 32'h4);
    irq = 8'h40;
    tick();
    irq = 8'h00;
    cs = 1'b1; mem_w = 1'b0; addr = A_CAUSE;
    tick();
    cs = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_output("t6_rst_int", {31'b0, INT}, 32'h0);
    check_output("t6_rst_ready", {31'b0, MIO_ready}, 32'h0);
    check_output("t6_rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    tick();
    reset = 1'b1;
    pulse_eret();
    check_int("t6_eret_ign0", 1'b0);
    check_int("t6_eret_ign1", 1'b0);
    bus_read("t6_pend", A_PEND, 32'h0);
    bus_read("t6_mask", A_MASK, 32'h0);
    bus_read("t6_cause0", A_CAUSE, 32'h0);
    bus_read("t6_ctrl", A_CTRL, 32'h0);

    // Reset while INT is high drops it without waiting for a clock.
    bus_write("t7_mask_w", A_MASK, 32'h01);
    bus_write("t7_ctrl_w", A_CTRL, 32'h1);
    irq = 8'h01;
    check_int("t7_int_c0", 1'b0);
    irq = 8'h00;
    check_int("t7_int_c1", 1'b0);
    check_int("t7_int_c2", 1'b1);
    #2 reset = 1'b0;
    #1;
    check_output("t7_async_int", {31'b0, INT}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
